fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter and fetch sequencer for the 9-bit-instruction core. Owns the 16-bit PC register that addresses the instruction ROM. Computes the next PC from sequential increment, absolute or relative branch targets (via a branch-target lookup table), stall and halt. Sits directly upstream of the instruction ROM and consumes the decoder's branch controls; reports run/done status and an optional cycle count to the testbench.

## Interface
- PW, 16, PC width; matches the instruction ROM address width
- IW, 9, instruction width
- LW, 4, branch-LUT index width (2**LW entries)
- START_PC, 16'h0000, PC loaded on start
- HALT_INST, 9'h1FF, encoding that terminates the program
- CLK  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled start request
- stall  in  1  hold PC this cycle
- inst  in  IW  current instruction, combinational from the ROM at PC
- br_abs  in  1  absolute branch request from decoder
- br_rel  in  1  relative branch request from decoder
- br_cond  in  1  branch condition (e.g. register==0); branch taken only if 1
- br_idx  in  LW  branch-LUT index
- PC  out  PW  program counter to the instruction ROM
- running  out  1  high in RUN
- done  out  1  high in HALT
- cycle_count  out  16  RUN cycles since last start (macro-gated)

## Operation
- States: IDLE, RUN, HALT. Reset: IDLE, PC=0, running=0, done=0, cycle_count=0.
- IDLE: PC holds 0. start=1 -> PC<=START_PC, cycle_count<=0, go RUN.
- RUN, evaluated each cycle in this priority order:
  - inst==HALT_INST -> go HALT, PC holds. Halt wins over stall and branches.
  - stall=1 -> PC holds.
  - br_abs & br_cond -> PC<=lut[br_idx].
  - br_rel & br_cond -> PC<=PC+lut[br_idx]. LUT value is a signed 16-bit offset; the sum is modulo 2**16.
  - Otherwise PC<=PC+1. 16'hFFFF wraps to 16'h0000.
- br_abs and br_rel both high: br_abs wins. A branch with br_cond=0 falls through to PC+1.
- start in RUN: ignored.
- HALT: PC holds, done=1. start=1 -> PC<=START_PC, cycle_count<=0, done<=0, go RUN.
- Branch LUT: combinational constant ROM, 2**LW x 16 bits. Unlisted entries are 0.
- rst_n low at any time, including mid-RUN: immediate return to the reset values above.

## Timing
- PC is registered. inst is valid in the same cycle as PC (combinational ROM). br_* are combinational from inst. The next PC appears after one edge, giving one instruction per cycle with no bubbles.
- start sampled at edge N -> PC=START_PC and running=1 after edge N.
- Halt instruction at PC in cycle N -> done=1 and running=0 after edge N. PC stays on the halt address.
- Branch/stall decisions use same-cycle inputs; there is no delay slot.

## Configuration
- FETCH_CYCLE_CNT_EN defined:
  - cycle_count increments on every RUN edge, stall cycles included.
  - The halting edge is counted.
  - Saturates at 16'hFFFF.
  - Cleared on start.
- FETCH_CYCLE_CNT_EN undefined: no counter register; cycle_count tied to 0.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, RUN, HALT)
  - the PW/IW/LW constants
  - HALT_INST
- One sub-module: fetch_lut, a combinational branch-target ROM, br_idx -> 16-bit target/offset.
- The FSM and PC mux live in fetch_ctrl.

## Test plan
- Reset and start, straight line: assert rst_n low mid-RUN -> PC=0, running=0, done=0 immediately. Release and pulse start -> PC steps 0,1,2,3 on successive edges.
- Halt: inst=9'h1FF at PC=5 with br_abs=1 and stall=1 -> done=1, PC stays 5, cycle_count=6. A later start -> PC=0, done=0, cycle_count=0.
- Absolute branch: lut[2]=16'h0008; at PC=6 drive br_abs=1, br_cond=1, br_idx=2 -> PC=8. Repeat with br_cond=0 -> PC=7.
- Relative branch: lut[1]=16'hFFFD (-3); at PC=7 drive br_rel=1, br_cond=1 -> PC=4. Drive br_abs and br_rel together -> the absolute target is taken.
- Wrap: PC=16'hFFFF with no branch -> PC=0. PC=16'hFFFE with relative offset +3 -> PC=1.
- Stall: stall=1 for 3 cycles at PC=4 -> PC holds 4, cycle_count advances by 3 (macro on) or stays 0 (macro off). A start during RUN is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, halt encoding and FSM states for the fetch sequencer
package fetch_pkg;
    localparam int PW = 16;
    localparam int IW = 9;
    localparam int LW = 4;

    localparam logic [IW-1:0] HALT_INST = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;
endpackage

// File: rtl/fetch_lut.sv
// rtl/fetch_lut.sv - combinational branch-target ROM, index -> absolute target or signed offset
module fetch_lut
    import fetch_pkg::*;
(
    input  logic [LW-1:0] br_idx,
    output logic [PW-1:0] target
);
    always_comb begin
        target = '0;
        case (br_idx)
            4'd1:    target = 16'hFFFD;
            4'd2:    target = 16'h0008;
            4'd3:    target = 16'h0003;
            default: target = '0;
        endcase
    end
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC register and IDLE/RUN/HALT fetch sequencer
// Optional RUN-cycle counter enabled by FETCH_CYCLE_CNT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PW-1:0] START_PC = 16'h0000
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic [IW-1:0] inst,
    input  logic          br_abs,
    input  logic          br_rel,
    input  logic          br_cond,
    input  logic [LW-1:0] br_idx,
    output logic [PW-1:0] PC,
    output logic          running,
    output logic          done,
    output logic [15:0]   cycle_count
);
    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] lut_val;

    fetch_lut u_lut (
        .br_idx (br_idx),
        .target (lut_val)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Halt outranks stall, which outranks branches; adds wrap modulo 2**PW.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                end
            end
            RUN: begin
                if (inst == HALT_INST) begin
                    state_d = HALT;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (br_abs && br_cond) begin
                    pc_d = lut_val;
                end else if (br_rel && br_cond) begin
                    pc_d = pc_q + lut_val;
                end else begin
                    pc_d = pc_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign PC      = pc_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == HALT);

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != RUN && state_d == RUN) begin
            cnt_d = '0;
        end else if (state_q == RUN && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count = cnt_q;
`else
    assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with hand-computed directed vectors
module tb_fetch_ctrl;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [8:0]  inst = '0;
    logic        br_abs = 1'b0;
    logic        br_rel = 1'b0;
    logic        br_cond = 1'b0;
    logic [3:0]  br_idx = '0;
    logic [15:0] PC;
    logic        running;
    logic        done;
    logic [15:0] cycle_count;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        run;
        logic        dn;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    fetch_ctrl dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .inst        (inst),
        .br_abs      (br_abs),
        .br_rel      (br_rel),
        .br_cond     (br_cond),
        .br_idx      (br_idx),
        .PC          (PC),
        .running     (running),
        .done        (done),
        .cycle_count (cycle_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] cnt_exp(input logic [15:0] c);
`ifdef FETCH_CYCLE_CNT_EN
        return c;
`else
        return 16'h0000 & c;
`endif
    endfunction

    task automatic compare(input exp_t e);
        vectors++;
        if (PC !== e.pc || running !== e.run || done !== e.dn || cycle_count !== e.cnt) begin
            miscompares++;
            $display("FAIL %s: got PC=%h running=%b done=%b cnt=%h, want PC=%h running=%b done=%b cnt=%h",
                     e.name, PC, running, done, cycle_count, e.pc, e.run, e.dn, e.cnt);
        end
    endtask

    task automatic check_now(input string nm);
        exp_t e;
        e.name = nm; e.pc = 16'h0000; e.run = 1'b0; e.dn = 1'b0; e.cnt = 16'h0000;
        compare(e);
    endtask

    task automatic step(input string nm, input logic s, input logic st, input logic [8:0] in,
                        input logic a, input logic r, input logic c, input logic [3:0] ix,
                        input logic [15:0] epc, input logic er, input logic ed, input logic [15:0] ec);
        exp_t e;
        @(negedge CLK);
        start = s; stall = st; inst = in; br_abs = a; br_rel = r; br_cond = c; br_idx = ix;
        e.name = nm; e.pc = epc; e.run = er; e.dn = ed; e.cnt = cnt_exp(ec);
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        repeat (2) @(negedge CLK);
        check_now("reset_init");
        rst_n = 1'b1;

        step("idle_hold", 0,0,9'h000,0,0,0,4'd0, 16'h0000,0,0,16'd0);
        step("start1",    1,0,9'h000,0,0,0,4'd0, 16'h0000,1,0,16'd0);
        for (int i = 1; i <= 3; i++)
            step("seq_a",   0,0,9'h000,0,0,0,4'd0, 16'(i),1,0,16'(i));

        @(negedge CLK);
        #2 rst_n = 1'b0;
        #1 check_now("reset_mid_run");
        @(negedge CLK);
        check_now("reset_held");
        rst_n = 1'b1;

        step("start2",    1,0,9'h000,0,0,0,4'd0, 16'h0000,1,0,16'd0);
        for (int i = 1; i <= 5; i++)
            step("seq_b",   0,0,9'h000,0,0,0,4'd0, 16'(i),1,0,16'(i));
        step("halt",      0,1,9'h1FF,1,0,1,4'd2, 16'h0005,0,1,16'd6);
        step("halt_hold", 0,0,9'h000,0,0,0,4'd0, 16'h0005,0,1,16'd6);
        step("restart",   1,0,9'h000,0,0,0,4'd0, 16'h0000,1,0,16'd0);
        for (int i = 1; i <= 6; i++)
            step("seq_c",   0,0,9'h000,0,0,0,4'd0, 16'(i),1,0,16'(i));

        step("abs_taken", 0,0,9'h000,1,0,1,4'd2, 16'h0008,1,0,16'd7);
        step("rel_back",  0,0,9'h000,0,1,1,4'd1, 16'h0005,1,0,16'd8);
        step("seq_d",     0,0,9'h000,0,0,0,4'd0, 16'h0006,1,0,16'd9);
        step("abs_ncond", 0,0,9'h000,1,0,0,4'd2, 16'h0007,1,0,16'd10);
        step("rel_taken", 0,0,9'h000,0,1,1,4'd1, 16'h0004,1,0,16'd11);
        step("stall1",    0,1,9'h000,0,0,0,4'd0, 16'h0004,1,0,16'd12);
        step("stall2",    0,1,9'h000,1,0,1,4'd2, 16'h0004,1,0,16'd13);
        step("stall3",    1,1,9'h000,0,0,0,4'd0, 16'h0004,1,0,16'd14);
        step("start_ign", 1,0,9'h000,0,0,0,4'd0, 16'h0005,1,0,16'd15);
        step("abs_rel",   0,0,9'h000,1,1,1,4'd2, 16'h0008,1,0,16'd16);
        step("rel_m3_a",  0,0,9'h000,0,1,1,4'd1, 16'h0005,1,0,16'd17);
        step("rel_m3_b",  0,0,9'h000,0,1,1,4'd1, 16'h0002,1,0,16'd18);
        step("rel_under", 0,0,9'h000,0,1,1,4'd1, 16'hFFFF,1,0,16'd19);
        step("inc_wrap",  0,0,9'h000,0,0,0,4'd0, 16'h0000,1,0,16'd20);
        step("seq_e",     0,0,9'h000,0,0,0,4'd0, 16'h0001,1,0,16'd21);
        step("rel_to_fe", 0,0,9'h000,0,1,1,4'd1, 16'hFFFE,1,0,16'd22);
        step("rel_wrap",  0,0,9'h000,0,1,1,4'd3, 16'h0001,1,0,16'd23);
        step("halt2",     0,0,9'h1FF,0,1,1,4'd3, 16'h0001,0,1,16'd24);

        @(negedge CLK);
        inst = '0; br_rel = 1'b0; br_cond = 1'b0;
        @(negedge CLK);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
